// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: ALU mode codes, ZCSO flag bit positions,
// controller state encodings and the carry-in selection helper.
package alu_pkg;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_OR  = 4'd3;
  localparam logic [3:0] MODE_XOR = 4'd4;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_O = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_OPRD = 2'd1;
  localparam state_t ST_EXEC = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Carry chaining: only a command that asks for it sees the stored C flag.
  function automatic logic carry_in(input logic use_carry, input logic [3:0] flags);
    return use_carry & flags[FLG_C];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port,
// R0 hardwired to zero, synchronous reset clears every entry.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the 8-bit ALU: accepts one command at a time,
// drives the ALU from registered operands, writes the result back and returns a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_mode,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          cmd_use_imm,
  input  logic [DW-1:0] cmd_imm,
  input  logic          cmd_use_carry,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [3:0]    alu_mode,
  output logic          alu_ci,
  input  logic [DW-1:0] alu_result,
  input  logic [3:0]    alu_flags,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic [3:0]    rsp_flags,
  output logic [3:0]    flags_q
);

  state_t        state_q, state_d;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] op1_q, op2_q;
  logic [3:0]    mode_q;
  logic          ci_q;
  logic [DW-1:0] rsp_result_q;
  logic [3:0]    rsp_flags_q;

  logic [DW-1:0] rf_rdata_a, rf_rdata_b;
  logic          accept;
  logic          exec;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign exec      = (state_q == ST_EXEC);

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (cmd_rs1),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (cmd_rs2),
    .rdata_b_o (rf_rdata_b),
    .we_i      (exec),
    .waddr_i   (rd_q),
    .wdata_i   (alu_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_OPRD;
      ST_OPRD:                state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operands are read on the accept edge so they are already valid throughout OPRD and EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      mode_q  <= '0;
      ci_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q   <= cmd_rd;
        op1_q  <= rf_rdata_a;
        op2_q  <= cmd_use_imm ? cmd_imm : rf_rdata_b;
        mode_q <= cmd_mode;
        ci_q   <= carry_in(cmd_use_carry, flags_q);
      end
    end
  end

  // End of EXEC: result and flags are captured together with the register writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
    end else if (exec) begin
      rsp_result_q <= alu_result;
      rsp_flags_q  <= alu_flags;
      flags_q      <= alu_flags;
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_mode   = mode_q;
  assign alu_ci     = ci_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

  a_rsp_hold: assert property (@(posedge clk)
    (!rst && rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_flags)));

  a_ops_hold: assert property (@(posedge clk)
    (!rst && (state_q != ST_IDLE)) |=> ($stable(alu_op1) && $stable(alu_op2) && $stable(alu_mode) && $stable(alu_ci)));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl with a behavioural ALU and a
// transaction-level reference model checked every cycle.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_mode = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic          cmd_use_imm = 1'b0;
  logic [DW-1:0] cmd_imm = '0;
  logic          cmd_use_carry = 1'b0;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [3:0]    alu_mode, alu_flags;
  logic          alu_ci;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags, flags_q;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_use_carry(cmd_use_carry),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_mode(alu_mode), .alu_ci(alu_ci),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags_q(flags_q)
  );

  function automatic logic [11:0] alu_eval(input logic [3:0] m, input logic [7:0] a,
                                           input logic [7:0] b, input logic ci);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, o;
    logic [3:0] f;
    s = 9'd0;
    c = 1'b0;
    o = 1'b0;
    case (m)
      MODE_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        c = s[8];
        o = (a[7] == b[7]) && (s[7] != a[7]);
      end
      MODE_SUB: begin
        s = {1'b0, a} - {1'b0, b} - {8'd0, ci};
        c = s[8];
        o = (a[7] != b[7]) && (s[7] != a[7]);
      end
      MODE_AND: s = {1'b0, a & b};
      MODE_OR:  s = {1'b0, a | b};
      MODE_XOR: s = {1'b0, a ^ b};
      default:  s = {1'b0, a};
    endcase
    r = s[7:0];
    f[FLG_Z] = (r == 8'd0);
    f[FLG_C] = c;
    f[FLG_S] = r[7];
    f[FLG_O] = o;
    return {r, f};
  endfunction

  // ALU stand-in wired between the alu_* ports.
  always_comb {alu_result, alu_flags} = alu_eval(alu_mode, alu_op1, alu_op2, alu_ci);

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: architectural registers plus one command in flight with its age in cycles.
  logic [7:0]    regs_m [NREG];
  logic [3:0]    flags_m;
  bit            busy;
  int            age;
  logic [7:0]    e_op1, e_op2, e_res, e_rsp_res;
  logic [3:0]    e_mode, e_fl, e_rsp_fl;
  logic          e_ci;
  logic [AW-1:0] e_rd;

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0;
      age  = 0;
      for (int i = 0; i < NREG; i++) regs_m[i] = 8'd0;
      flags_m   = 4'd0;
      e_op1     = 8'd0;
      e_op2     = 8'd0;
      e_mode    = 4'd0;
      e_ci      = 1'b0;
      e_rd      = '0;
      e_res     = 8'd0;
      e_fl      = 4'd0;
      e_rsp_res = 8'd0;
      e_rsp_fl  = 4'd0;
    end else if (!busy) begin
      if (cmd_valid) begin
        busy   = 1'b1;
        age    = 0;
        e_op1  = regs_m[cmd_rs1];
        e_op2  = cmd_use_imm ? cmd_imm : regs_m[cmd_rs2];
        e_mode = cmd_mode;
        e_ci   = cmd_use_carry & flags_m[FLG_C];
        e_rd   = cmd_rd;
        {e_res, e_fl} = alu_eval(e_mode, e_op1, e_op2, e_ci);
      end
    end else if (age == 0) begin
      age = 1;
    end else if (age == 1) begin
      if (e_rd != '0) regs_m[e_rd] = e_res;
      flags_m   = e_fl;
      e_rsp_res = e_res;
      e_rsp_fl  = e_fl;
      age       = 2;
    end else if (rsp_ready) begin
      busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_ready",  32'(cmd_ready),  32'(!busy));
      chk("rsp_valid",  32'(rsp_valid),  32'(busy && age == 2));
      chk("alu_op1",    32'(alu_op1),    32'(e_op1));
      chk("alu_op2",    32'(alu_op2),    32'(e_op2));
      chk("alu_mode",   32'(alu_mode),   32'(e_mode));
      chk("alu_ci",     32'(alu_ci),     32'(e_ci));
      chk("rsp_result", 32'(rsp_result), 32'(e_rsp_res));
      chk("rsp_flags",  32'(rsp_flags),  32'(e_rsp_fl));
      chk("flags_q",    32'(flags_q),    32'(flags_m));
    end
  end

  // Issues one command from a negedge and returns at the negedge where IDLE is visible again.
  task automatic do_cmd(input logic [3:0] m, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic ui, input logic [7:0] imm,
                        input logic uc, input int hold,
                        output logic [7:0] res, output logic [3:0] fl);
    int w;
    int lat;
    cmd_mode = m; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_use_imm = ui; cmd_imm = imm; cmd_use_carry = uc;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(w), 32'(0));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_imm   = 8'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(3));
    res = rsp_result;
    fl  = rsp_flags;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_valid",     32'(rsp_valid),  32'(1));
      chk("hold_cmd_ready", 32'(cmd_ready),  32'(0));
      chk("hold_result",    32'(rsp_result), 32'(res));
      chk("hold_flags",     32'(rsp_flags),  32'(fl));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [7:0] r;
  logic [3:0] f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready",  32'(cmd_ready),  32'(1));
    chk("reset_rsp_valid",  32'(rsp_valid),  32'(0));
    chk("reset_rsp_result", 32'(rsp_result), 32'(0));
    chk("reset_flags_q",    32'(flags_q),    32'(0));
    chk("reset_alu_op1",    32'(alu_op1),    32'(0));
    chk("reset_alu_ci",     32'(alu_ci),     32'(0));

    do_cmd(MODE_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'd1, 1'b0, 0, r, f);
    do_cmd(MODE_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'd2, 1'b0, 0, r, f);
    do_cmd(MODE_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 8'd0, 1'b0, 0, r, f);
    chk("t1_result", 32'(r), 32'h03);
    chk("t1_flags",  32'(f), 32'h0);

    do_cmd(MODE_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b0, 0, r, f);
    do_cmd(MODE_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'hFE, 1'b0, 0, r, f);
    do_cmd(MODE_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 8'd0, 1'b0, 0, r, f);
    chk("t2_result",  32'(r),       32'hFD);
    chk("t2_flags_q", 32'(flags_q), 32'b0110);

    do_cmd(MODE_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'd127, 1'b0, 0, r, f);
    do_cmd(MODE_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'd1, 1'b0, 0, r, f);
    chk("t3_result", 32'(r), 32'h80);
    chk("t3_flags",  32'(f), 32'b0011);
    do_cmd(MODE_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'd0, 1'b1, 0, r, f);
    chk("t3_ci_clear", 32'(alu_ci), 32'(0));

    do_cmd(MODE_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'd126, 1'b0, 0, r, f);
    do_cmd(MODE_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h82, 1'b0, 0, r, f);
    chk("t4_result", 32'(r), 32'h00);
    chk("t4_flags",  32'(f), 32'b1100);
    do_cmd(MODE_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'd0, 1'b1, 0, r, f);
    chk("t4_ci_set",   32'(alu_ci), 32'(1));
    chk("t4_ci_sum",   32'(r),      32'h01);

    do_cmd(MODE_SUB, 2'd3, 2'd3, 2'd1, 1'b0, 8'd0, 1'b0, 5, r, f);
    chk("t5_same_reg", 32'(r), 32'h83);
    chk("t5_idle_ready", 32'(cmd_ready), 32'(1));

    do_cmd(MODE_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55, 1'b0, 0, r, f);
    cmd_mode = MODE_ADD; cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd0;
    cmd_use_imm = 1'b1; cmd_imm = 8'h11; cmd_use_carry = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("t6_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("t6_flags_q",   32'(flags_q),   32'(0));
    do_cmd(MODE_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'd0, 1'b0, 0, r, f);
    chk("t6_no_wb", 32'(r), 32'h00);
    do_cmd(MODE_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'd5, 1'b0, 0, r, f);
    chk("t6_r0_result", 32'(r), 32'h05);
    do_cmd(MODE_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'd0, 1'b0, 0, r, f);
    chk("t6_r0_reads_zero", 32'(alu_op1), 32'(0));

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 80) == 0);
      cmd_valid     = 1'($urandom);
      cmd_mode      = 4'($urandom_range(0, 5));
      cmd_rd        = 2'($urandom);
      cmd_rs1       = 2'($urandom);
      cmd_rs2       = 2'($urandom);
      cmd_use_imm   = 1'($urandom);
      cmd_imm       = 8'($urandom);
      cmd_use_carry = 1'($urandom);
      rsp_ready     = 1'($urandom);
    end
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
